// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master data bus arbiter, master 0 priority with master 1 starvation guard
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemBus_Address,
    output logic [DATA_W-1:0] MemBus_Write_Data,
    input  logic [DATA_W-1:0] Device_Read_Data,
    input  logic              perf_clr,
    output logic [31:0]       perf_m0_cnt,
    output logic [31:0]       perf_m1_cnt,
    output logic [31:0]       perf_conf_cnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic       req0, req1;
    logic [7:0] starve_q, starve_d;
    logic       m0_rvalid_q, m1_rvalid_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    // Requests are masked during reset so grants and strobes stay low.
    assign req0 = m0_req & ~reset;
    assign req1 = m1_req & ~reset;

    always_comb begin
        m0_gnt            = 1'b0;
        m1_gnt            = 1'b0;
        MemRead           = 1'b0;
        MemWrite          = 1'b0;
        MemBus_Address    = '0;
        MemBus_Write_Data = '0;
        starve_d          = starve_q;

        if (req1 && (!req0 || starve_q == LIMIT)) begin
            m1_gnt = 1'b1;
        end else if (req0) begin
            m0_gnt = 1'b1;
        end

        if (m0_gnt) begin
            MemRead           = ~m0_we;
            MemWrite          = m0_we;
            MemBus_Address    = m0_addr;
            MemBus_Write_Data = m0_wdata;
        end else if (m1_gnt) begin
            MemRead           = ~m1_we;
            MemWrite          = m1_we;
            MemBus_Address    = m1_addr;
            MemBus_Write_Data = m1_wdata;
        end

        if (m1_gnt || !req1) begin
            starve_d = 8'd0;
        end else if (m0_gnt && starve_q < LIMIT) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q    <= 8'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            starve_q    <= starve_d;
            m0_rvalid_q <= m0_gnt & ~m0_we;
            m1_rvalid_q <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) m0_rdata_q <= Device_Read_Data;
            if (m1_gnt && !m1_we) m1_rdata_q <= Device_Read_Data;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_m0_q, perf_m1_q, perf_conf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_m0_q   <= 32'd0;
            perf_m1_q   <= 32'd0;
            perf_conf_q <= 32'd0;
        end else if (perf_clr) begin
            perf_m0_q   <= 32'd0;
            perf_m1_q   <= 32'd0;
            perf_conf_q <= 32'd0;
        end else begin
            perf_m0_q   <= perf_m0_q + {31'd0, m0_gnt};
            perf_m1_q   <= perf_m1_q + {31'd0, m1_gnt};
            perf_conf_q <= perf_conf_q + {31'd0, req0 & req1};
        end
    end

    assign perf_m0_cnt   = perf_m0_q;
    assign perf_m1_cnt   = perf_m1_q;
    assign perf_conf_cnt = perf_conf_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_m0_cnt     = 32'd0;
    assign perf_m1_cnt     = 32'd0;
    assign perf_conf_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] MemBus_Address, MemBus_Write_Data, Device_Read_Data;
    logic        perf_clr;
    logic [31:0] perf_m0_cnt, perf_m1_cnt, perf_conf_cnt;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
        .Device_Read_Data(Device_Read_Data),
        .perf_clr(perf_clr),
        .perf_m0_cnt(perf_m0_cnt), .perf_m1_cnt(perf_m1_cnt), .perf_conf_cnt(perf_conf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h100; m1_addr = 32'h200;
        m0_wdata = 32'h0; m1_wdata = 32'h0;
        Device_Read_Data = 32'hCAFE0000;
        perf_clr = 1'b0;
        step();
        step();

        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_memread", MemRead, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_addr", MemBus_Address, 0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_perf", {perf_m0_cnt, perf_conf_cnt}, 0);

        // Continuous contention: m0 x4 then m1, repeating; first cycle after reset grants m0.
        reset = 1'b0;
        #1;
        chk("first_gnt_addr", MemBus_Address, 32'h100);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("cont_m0_gnt_%0d", i), m0_gnt, (i % 5 != 4));
            chk($sformatf("cont_m1_gnt_%0d", i), m1_gnt, (i % 5 == 4));
            chk($sformatf("cont_addr_%0d", i), MemBus_Address, (i % 5 == 4) ? 32'h200 : 32'h100);
            step();
            chk($sformatf("cont_m0_rv_%0d", i), m0_rvalid, (i % 5 != 4));
            chk($sformatf("cont_m1_rv_%0d", i), m1_rvalid, (i % 5 == 4));
            #1;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
`ifdef MEM_ARB_PERF_EN
        chk("perf_conf", perf_conf_cnt, 10);
        chk("perf_m0", perf_m0_cnt, 8);
        chk("perf_m1", perf_m1_cnt, 2);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        chk("perf_clr_conf", perf_conf_cnt, 0);
        chk("perf_clr_m0", perf_m0_cnt, 0);
        chk("perf_clr_m1", perf_m1_cnt, 0);
`else
        chk("perf_off_conf", perf_conf_cnt, 0);
        chk("perf_off_m0", perf_m0_cnt, 0);
        chk("perf_off_m1", perf_m1_cnt, 0);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
`endif
        chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
        chk("idle_strobes", {MemRead, MemWrite}, 0);

        // Uncontested m1 read.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; Device_Read_Data = 32'hDEADBEEF;
        #1;
        chk("m1rd_gnt", m1_gnt, 1);
        chk("m1rd_memread", MemRead, 1);
        chk("m1rd_addr", MemBus_Address, 32'h10);
        step();
        m1_req = 1'b0; Device_Read_Data = 32'h0;
        chk("m1rd_rvalid", m1_rvalid, 1);
        chk("m1rd_rdata", m1_rdata, 32'hDEADBEEF);
        chk("m1rd_m0_rvalid", m0_rvalid, 0);
        step();
        chk("m1rd_rvalid_pulse", m1_rvalid, 0);
        chk("m1rd_rdata_hold", m1_rdata, 32'hDEADBEEF);

        // Interleaved reads, no cross-attribution.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; Device_Read_Data = 32'h11;
        #1;
        chk("il_m0_gnt", m0_gnt, 1);
        step();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4; Device_Read_Data = 32'h22;
        #1;
        chk("il_m1_gnt", m1_gnt, 1);
        chk("il_m0_rvalid", m0_rvalid, 1);
        chk("il_m0_rdata", m0_rdata, 32'h11);
        chk("il_m1_rvalid_early", m1_rvalid, 0);
        step();
        m1_req = 1'b0;
        chk("il_m1_rvalid", m1_rvalid, 1);
        chk("il_m1_rdata", m1_rdata, 32'h22);
        chk("il_m0_rvalid_done", m0_rvalid, 0);
        chk("il_m0_rdata_hold", m0_rdata, 32'h11);

        // m0 write: one cycle of MemWrite, no rvalid afterwards.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h5A;
        #1;
        chk("wr_memwrite", MemWrite, 1);
        chk("wr_memread", MemRead, 0);
        chk("wr_addr", MemBus_Address, 32'h20);
        chk("wr_data", MemBus_Write_Data, 32'h5A);
        step();
        m0_req = 1'b0; m0_we = 1'b0;
        #1;
        chk("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
        chk("wr_done_strobe", MemWrite, 0);
        chk("wr_done_addr", MemBus_Address, 0);

        // Read granted just before reset produces no rvalid.
        m0_req = 1'b1; m0_addr = 32'h30; Device_Read_Data = 32'h77;
        #2;
        chk("rr_gnt", m0_gnt, 1);
        reset = 1'b1;
        #1;
        chk("rr_gnt_in_reset", m0_gnt, 0);
        step();
        chk("rr_no_rvalid", m0_rvalid, 0);
        chk("rr_rdata_clr", m0_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the CPU's single data memory/device bus (`MemRead`, `MemWrite`, `MemBus_Address`, `MemBus_Write_Data`, `Device_Read_Data`) between the pipeline's MEM stage (master 0) and a DMA/loader engine (master 1). It sits between the CPU core and the data memory/peripheral decoder. It issues at most one access per cycle. Master 0 has fixed priority, and a starvation counter guarantees master 1 forward progress. Read data is registered and returned one cycle after the grant.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: consecutive cycles master 1 may be denied before it is forced a grant. Legal range 1..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` input 1 each: access request. Must be held, together with `we`/`addr`/`wdata`, until `gnt`.
- `m0_we`, `m1_we` input 1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` input ADDR_W each: access address.
- `m0_wdata`, `m1_wdata` input DATA_W each: write data.
- `m0_gnt`, `m1_gnt` output 1 each: combinational. The access is issued on the bus this cycle.
- `m0_rvalid`, `m1_rvalid` output 1 each: registered one-cycle pulse carrying read data.
- `m0_rdata`, `m1_rdata` output DATA_W each: registered read data, valid with `rvalid`.
- `MemRead`, `MemWrite` output 1 each: bus strobes.
- `MemBus_Address` output ADDR_W: bus address.
- `MemBus_Write_Data` output DATA_W: bus write data.
- `Device_Read_Data` input DATA_W: combinational read data from memory/devices, valid in the same cycle as `MemRead`.
- `perf_clr` input 1: synchronous clear of the performance counters.
- `perf_m0_cnt`, `perf_m1_cnt`, `perf_conf_cnt` output 32 each: performance counters (see Configuration).

## Operation
- **Arbitration, evaluated combinationally every cycle:**
  - Only one master requests: that master is granted.
  - Both request and `starve_cnt == STARVE_LIMIT`: master 1 is granted.
  - Both request otherwise: master 0 is granted.
  - Neither requests: no grant.
- **Bus mux:**
  - Granted master's `addr`/`wdata` drive the bus.
  - `MemWrite = gnt & we`; `MemRead = gnt & ~we`.
  - No grant: strobes 0, address 0, write data 0.
- **Starvation counter `starve_cnt`** (8 bits, registered):
  - Increments when `m1_req & m0_gnt`.
  - Clears to 0 when `m1_gnt` or `~m1_req`.
  - Otherwise holds.
  - Never exceeds `STARVE_LIMIT`.
- **Read return:**
  - On a granted read, `Device_Read_Data` is captured into the granted master's `rdata`.
  - That master's `rvalid` is asserted for exactly the next cycle.
  - `rdata` holds its value until the next read return for the same master.
- **Write completion:** a write completes in its grant cycle. There is no response.
- **Request withdrawal:** dropping `req` before `gnt` is illegal and need not be handled.

## Timing
- Grant latency: 0 cycles for an uncontested request. A contested master 1 waits at most `STARVE_LIMIT` cycles.
- Read latency: `rvalid` is asserted 1 cycle after the granted read cycle.
- Back-to-back reads from the same or alternating masters are sustained at 1 per cycle. Each `rvalid` is attributed to the master granted in the previous cycle.
- **Reset asserted (asynchronous):**
  - Outputs: `gnt`s 0, strobes 0, bus address/data 0, `rvalid`s 0, `rdata` 0.
  - State: `starve_cnt` 0; counters 0.
  - A read granted in the cycle before reset produces no `rvalid`.
- **Reset deassertion:** arbitration resumes in the first cycle after reset is low.
- **Simultaneous events:** a read grant and an `rvalid` for the other master in the same cycle are independent and both occur.

## Configuration
- Macro `MEM_ARB_PERF_EN`.
- **Defined:**
  - `perf_m0_cnt` increments on each `m0_gnt`.
  - `perf_m1_cnt` increments on each `m1_gnt`.
  - `perf_conf_cnt` increments on each cycle with both requests.
  - All three counters wrap at 2^32.
  - `perf_clr` zeroes all three counters on the next edge; clear wins over an increment in the same cycle.
- **Undefined:** counters are not built. The three outputs are constant 0 and `perf_clr` is ignored. Ports remain so integration is unchanged.

## Test plan
- **Reset:** hold `reset` high with both `req` = 1 -> all `gnt`, strobes, `rvalid` = 0. Release -> first cycle grants m0.
- **Uncontested read:** m1 reads addr 0x10, `Device_Read_Data` = 0xDEADBEEF -> `m1_gnt` and `MemRead` = 1 in the same cycle. Next cycle `m1_rvalid` = 1 and `m1_rdata` = 0xDEADBEEF. `m0_rvalid` stays 0.
- **Continuous contention, `STARVE_LIMIT` = 4:** both masters request every cycle -> grant pattern m0,m0,m0,m0,m1 repeating. `starve_cnt` runs 1..4 and then returns to 0.
- **Interleaved reads:** m0 reads 0x0 (data 0x11), next cycle m1 reads 0x4 (data 0x22) -> `m0_rvalid` with 0x11 in cycle 2, `m1_rvalid` with 0x22 in cycle 3, no cross-attribution.
- **Write:** m0 write 0x20 ← 0x5A -> `MemWrite` = 1, `MemBus_Address` = 0x20, `MemBus_Write_Data` = 0x5A for one cycle. No `rvalid` follows.
- **Counters:** with `MEM_ARB_PERF_EN`, run 10 contended cycles -> `perf_conf_cnt` = 10, `perf_m0_cnt` = 8, `perf_m1_cnt` = 2. Pulse `perf_clr` -> all three counters read 0 next cycle.
